// File: rtl/wb_req_arbiter.sv
// Two-requester arbiter in front of a single Wishbone master: one transaction at a time.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module wb_req_arbiter #(
   parameter int DATA_WL = 16,
   parameter int ADR_WL  = 16
) (
   input  logic               clk,
   input  logic               a_reset_l,
   input  logic               req0_i,
   input  logic               req0_we_i,
   input  logic [ADR_WL-1:0]  req0_addr_i,
   input  logic [DATA_WL-1:0] req0_data_i,
   input  logic               req1_i,
   input  logic               req1_we_i,
   input  logic [ADR_WL-1:0]  req1_addr_i,
   input  logic [DATA_WL-1:0] req1_data_i,
   output logic               gnt0_o,
   output logic               gnt1_o,
   output logic               done0_o,
   output logic               done1_o,
   output logic [DATA_WL-1:0] rdata_o,
   output logic               m_start_o,
   output logic               m_we_o,
   output logic [ADR_WL-1:0]  m_addr_o,
   output logic [DATA_WL-1:0] m_data_o,
   input  logic               m_busy_i,
   input  logic               m_valid_i,
   input  logic [DATA_WL-1:0] m_data_i
);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      ISSUE = 4'b0010,
      WAIT  = 4'b0100,
      RESP  = 4'b1000
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         gnt_q, gnt_d;
   logic               we_q, we_d;
   logic [ADR_WL-1:0]  addr_q, addr_d;
   logic [DATA_WL-1:0] data_q, data_d;
   logic [DATA_WL-1:0] rdata_q, rdata_d;
   logic               first_q, first_d;
   logic               win1;

`ifdef WB_ARB_ROUND_ROBIN_EN
   // rr_q set means requester 1 is favoured on a tie
   logic rr_q, rr_d;
   assign win1 = req1_i & (~req0_i | rr_q);
`else
   assign win1 = req1_i & ~req0_i;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      first_d = first_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
      rr_d    = rr_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0_i || req1_i) begin
               gnt_d   = win1 ? 2'b10 : 2'b01;
               we_d    = win1 ? req1_we_i   : req0_we_i;
               addr_d  = win1 ? req1_addr_i : req0_addr_i;
               data_d  = win1 ? req1_data_i : req0_data_i;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            first_d = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            // master only raises busy a cycle after start, so valid left over
            // from the previous transaction must not count in the first cycle
            first_d = 1'b0;
            if (!first_q && !m_busy_i && m_valid_i) begin
               rdata_d = m_data_i;
               state_d = RESP;
            end
         end
         RESP: begin
            gnt_d   = 2'b00;
            state_d = IDLE;
`ifdef WB_ARB_ROUND_ROBIN_EN
            rr_d    = gnt_q[0];
`endif
         end
         default: begin
            gnt_d   = 2'b00;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge a_reset_l) begin
      if (!a_reset_l) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         first_q <= 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
         rr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         first_q <= first_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
         rr_q    <= rr_d;
`endif
      end
   end

   assign gnt0_o    = gnt_q[0];
   assign gnt1_o    = gnt_q[1];
   assign done0_o   = (state_q == RESP) && gnt_q[0];
   assign done1_o   = (state_q == RESP) && gnt_q[1];
   assign m_start_o = (state_q == ISSUE);
   assign m_we_o    = we_q;
   assign m_addr_o  = addr_q;
   assign m_data_o  = data_q;
   assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_wb_req_arbiter.sv
// Scoreboard bench for wb_req_arbiter: directed stimulus pushes expected transactions,
// a monitor pops them on every done pulse; a behavioural master answers start pulses.
module tb_wb_req_arbiter;
   localparam int DW = 16;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          a_reset_l = 1'b0;
   logic          req0_i = 0, req0_we_i = 0, req1_i = 0, req1_we_i = 0;
   logic [AW-1:0] req0_addr_i = '0, req1_addr_i = '0;
   logic [DW-1:0] req0_data_i = '0, req1_data_i = '0;
   logic          gnt0_o, gnt1_o, done0_o, done1_o, m_start_o, m_we_o;
   logic [DW-1:0] rdata_o, m_data_o;
   logic [AW-1:0] m_addr_o;
   logic          m_busy_i = 0, m_valid_i = 0;
   logic [DW-1:0] m_data_i = '0;

   wb_req_arbiter #(.DATA_WL(DW), .ADR_WL(AW)) dut (
      .clk(clk), .a_reset_l(a_reset_l),
      .req0_i(req0_i), .req0_we_i(req0_we_i), .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
      .req1_i(req1_i), .req1_we_i(req1_we_i), .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
      .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .done0_o(done0_o), .done1_o(done1_o),
      .rdata_o(rdata_o), .m_start_o(m_start_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
      .m_data_o(m_data_o), .m_busy_i(m_busy_i), .m_valid_i(m_valid_i), .m_data_i(m_data_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic          who;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] resp_q[$];
   int            checks = 0, errors = 0;

   // master model knobs
   int lat = 3, busy_dly = 1, comp_cyc = -100;
   bit stale = 0, hold_busy = 0, b2b_chk = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(logic who, logic we, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] r);
      exp_t e;
      e.who = who; e.we = we; e.addr = a; e.data = d; e.rdata = r;
      exp_q.push_back(e);
      resp_q.push_back(r);
   endtask

   task automatic wait_dones(int n);
      int seen = 0;
      int t = 0;
      while (seen < n && t < 300) begin
         @(negedge clk);
         t++;
         if (done0_o || done1_o) seen++;
      end
      if (seen < n) begin
         checks++; errors++;
         $display("FAIL done_timeout: got %0d done pulses expected %0d", seen, n);
      end
   endtask

   // behavioural Wishbone master
   initial begin
      forever begin
         @(negedge clk);
         if (m_start_o) begin
            if (!stale) m_valid_i = 0;
            repeat (busy_dly) @(posedge clk);
            #1 m_busy_i = 1;
            if (hold_busy) begin
               wait (!a_reset_l);
               m_busy_i = 0; m_valid_i = 0;
            end else begin
               repeat (lat) @(posedge clk);
               #1;
               m_busy_i = 0; m_valid_i = 1;
               m_data_i = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
               comp_cyc = cyc;
               @(posedge clk);
               #1 if (!stale) m_valid_i = 0;
            end
         end
      end
   end

   // monitor / scoreboard
   initial begin
      logic          st_we;
      logic [AW-1:0] st_addr;
      logic [DW-1:0] st_data;
      int            last_done;
      exp_t          e;
      last_done = -100;
      st_we = 0; st_addr = '0; st_data = '0;
      forever begin
         @(negedge clk);
         if (gnt0_o || gnt1_o) chk("gnt_exclusive", {31'd0, gnt0_o & gnt1_o}, 0);
         if (m_start_o) begin
            st_we = m_we_o; st_addr = m_addr_o; st_data = m_data_o;
            if (b2b_chk) begin
               chk("b2b_start_gap", cyc - last_done, 2);
               b2b_chk = 0;
            end
         end
         if (done0_o || done1_o) begin
            last_done = cyc;
            chk("done_exclusive", {31'd0, done0_o & done1_o}, 0);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none", done0_o, done1_o);
            end else begin
               e = exp_q.pop_front();
               chk("done_who", {31'd0, done1_o}, {31'd0, e.who});
               chk("gnt_at_done", {31'd0, e.who ? gnt1_o : gnt0_o}, 1);
               chk("start_cmd", {15'd0, st_we, st_addr}, {15'd0, e.we, e.addr});
               chk("start_wdata", {16'd0, st_data}, {16'd0, e.data});
               chk("done_cmd", {15'd0, m_we_o, m_addr_o}, {15'd0, e.we, e.addr});
               chk("done_wdata", {16'd0, m_data_o}, {16'd0, e.data});
               chk("rdata", {16'd0, rdata_o}, {16'd0, e.rdata});
               chk("completion_latency", cyc - comp_cyc, 1);
            end
         end
      end
   end

   // stimulus
   initial begin
      logic w;
      int t;
      repeat (2) @(negedge clk);
      chk("rst_gnt", {30'd0, gnt1_o, gnt0_o}, 0);
      chk("rst_done", {30'd0, done1_o, done0_o}, 0);
      chk("rst_start_we", {30'd0, m_start_o, m_we_o}, 0);
      chk("rst_addr", {16'd0, m_addr_o}, 0);
      chk("rst_data", {16'd0, m_data_o}, 0);
      chk("rst_rdata", {16'd0, rdata_o}, 0);
      a_reset_l = 1;
      @(negedge clk);

      // single read, 3 busy cycles
      lat = 3;
      push_exp(0, 0, 16'h0010, 16'h0000, 16'hBEEF);
      req0_we_i = 0; req0_addr_i = 16'h0010; req0_data_i = 0; req0_i = 1;
      wait_dones(1); req0_i = 0;
      repeat (3) @(negedge clk);
      chk("rdata_hold", {16'd0, rdata_o}, 16'hBEEF);

      // single write; requester inputs scrambled and request dropped after grant
      lat = 1;
      push_exp(1, 1, 16'h0200, 16'h1234, 16'h5A5A);
      req1_we_i = 1; req1_addr_i = 16'h0200; req1_data_i = 16'h1234; req1_i = 1;
      @(negedge clk);
      req1_i = 0; req1_we_i = 0; req1_addr_i = 16'hFFFF; req1_data_i = 16'hFFFF;
      wait_dones(1);
      req1_we_i = 1; req1_addr_i = 16'h0200; req1_data_i = 16'h1234;

      // contention over four transactions
      lat = 2;
      for (int i = 0; i < 4; i++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
         w = i[0];
`else
         w = 1'b0;
`endif
         if (w) push_exp(1, 1, 16'h0200, 16'h1234, 16'h1001 + 16'(i));
         else   push_exp(0, 0, 16'h0010, 16'h0000, 16'h1001 + 16'(i));
      end
      req0_i = 1; req1_i = 1;
      wait_dones(4);
      req0_i = 0; req1_i = 0;
      repeat (2) @(negedge clk);

      // back-to-back on requester 0
      lat = 1;
      push_exp(0, 0, 16'h0010, 16'h0000, 16'h2222);
      push_exp(0, 0, 16'h0010, 16'h0000, 16'h3333);
      req0_i = 1;
      wait_dones(1);
      req0_i = 0; b2b_chk = 1;
      @(posedge clk); #1 req0_i = 1;
      wait_dones(1); req0_i = 0;
      repeat (2) @(negedge clk);

      // stale valid with late busy
      stale = 1; busy_dly = 2; lat = 2;
      req0_addr_i = 16'h0030;
      push_exp(0, 0, 16'h0030, 16'h0000, 16'h7777);
      push_exp(0, 0, 16'h0030, 16'h0000, 16'h8888);
      req0_i = 1;
      wait_dones(2); req0_i = 0;
      stale = 0; busy_dly = 1;
      repeat (2) @(negedge clk);

      // reset while the master is busy
      hold_busy = 1;
      req1_we_i = 0; req1_addr_i = 16'h0040; req1_i = 1;
      t = 0;
      while (!m_start_o && t < 50) begin @(negedge clk); t++; end
      chk("abort_start_seen", {31'd0, m_start_o}, 1);
      repeat (2) @(posedge clk);
      #3 a_reset_l = 0;
      #1;
      chk("async_rst_gnt_done", {28'd0, gnt1_o, gnt0_o, done1_o, done0_o}, 0);
      chk("async_rst_cmd", {15'd0, m_we_o, m_addr_o}, 0);
      chk("async_rst_start", {31'd0, m_start_o}, 0);
      chk("async_rst_rdata", {16'd0, rdata_o}, 0);
      req1_i = 0; hold_busy = 0;
      repeat (2) @(negedge clk);
      a_reset_l = 1;
      repeat (3) @(negedge clk);

      // fresh request after reset
      lat = 2;
      req0_addr_i = 16'h0050;
      push_exp(0, 0, 16'h0050, 16'h0000, 16'hCAFE);
      req0_i = 1;
      wait_dones(1); req0_i = 0;
      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/wb_req_arbiter.md
WB_REQ_ARBITER -- requirements
Module: wb_req_arbiter

Interface
REQ-001 Parameters: DATA_WL, default 16, data width; ADR_WL, default 16, address width.
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 a_reset_l  in  1  reset, asynchronous, active-low.
REQ-004 reqN_i (N=0,1)  in  1  requester N transaction request, level, held until doneN_o.
REQ-005 reqN_we_i  in  1  requester N write enable (1=write, 0=read).
REQ-006 reqN_addr_i  in  ADR_WL  requester N address.
REQ-007 reqN_data_i  in  DATA_WL  requester N write data.
REQ-008 gntN_o  out  1  requester N owns the master, from grant through doneN_o.
REQ-009 doneN_o  out  1  one-cycle pulse, requester N transaction complete.
REQ-010 rdata_o  out  DATA_WL  read data of last completed transaction, shared by both requesters.
REQ-011 m_start_o  out  1  start pulse to Wishbone master.
REQ-012 m_we_o, m_addr_o, m_data_o  out  1/ADR_WL/DATA_WL  command to master, registered.
REQ-013 m_busy_i, m_valid_i  in  1  master busy and completion-valid status.
REQ-014 m_data_i  in  DATA_WL  master read data.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one-hot encoded, with any illegal encoding returning to IDLE.
REQ-016 IDLE: if any reqN_i=1, SHALL select a winner, latch its we/addr/data into m_we_o/m_addr_o/m_data_o, set gnt of the winner, and go to ISSUE next cycle.
REQ-017 ISSUE: m_start_o SHALL be 1 for exactly this one cycle; next state WAIT unconditionally.
REQ-018 WAIT: completion SHALL be m_busy_i=0 and m_valid_i=1; on completion, latch m_data_i into rdata_o and go to RESP; otherwise stay.
REQ-019 WAIT SHALL ignore the first WAIT cycle's m_valid_i (master raises busy one cycle after start).
REQ-020 RESP: doneN_o of the granted requester SHALL be 1 for this cycle only, gntN_o deasserts at the end of it, and the next state is IDLE.
REQ-021 Latency: request at IDLE to m_start_o SHALL be 1 cycle; master completion to doneN_o SHALL be 1 cycle.
REQ-022 Command outputs and the grant SHALL remain stable from ISSUE through RESP; requester input changes are ignored after the grant.
REQ-023 rdata_o SHALL hold its value until the next completion; it is also updated on write completions.
REQ-024 gnt0_o and gnt1_o SHALL never be 1 simultaneously; at most one doneN_o SHALL pulse per transaction.
REQ-025 A request withdrawn before the grant SHALL be treated as absent; withdrawal after the grant SHALL not abort the transaction.

Reset
REQ-026 Reset SHALL force IDLE; gntN_o, doneN_o, m_start_o, m_we_o = 0; m_addr_o, m_data_o, rdata_o = 0; round-robin pointer = requester 0 favoured.
REQ-027 Reset mid-transaction SHALL abandon it with no doneN_o pulse; after reset release the block SHALL start from IDLE.

Configuration
REQ-028 Macro WB_ARB_ROUND_ROBIN_EN defined: on simultaneous requests the requester not served last SHALL win; the pointer SHALL update in RESP to favour the other requester.
REQ-029 Macro WB_ARB_ROUND_ROBIN_EN undefined: fixed priority, req0_i always wins on simultaneous requests; no pointer register.

Verification
REQ-030 Single read: req0 read addr 0x0010, master returns 0xBEEF after 3 ack-wait cycles -> m_start_o one pulse with m_addr_o=0x0010, m_we_o=0; done0_o one pulse; rdata_o=0xBEEF.
REQ-031 Single write: req1 write addr 0x0200 data 0x1234 -> m_we_o=1, m_data_o=0x1234, gnt1_o high until done1_o, gnt0_o stays 0.
REQ-032 Contention: req0 and req1 asserted together, held for 4 transactions -> with RR_EN grants alternate 0,1,0,1; without it grants are 0,0,0,0 with req1 starved.
REQ-033 Back-to-back: req0 re-asserted the cycle after done0_o -> next m_start_o exactly 2 cycles after done0_o, with no glitch on gnt.
REQ-034 Reset in WAIT: a_reset_l low while m_busy_i=1 -> all outputs 0 asynchronously; no doneN_o pulse; a fresh request after release completes normally.
REQ-035 Stale valid: m_valid_i left high from the previous transaction while m_busy_i=1 -> no early doneN_o; done only after busy falls.
